// File: rtl/ps2_scancode_decoder_if.sv
// Byte-stream input and decoded key outputs of the PS/2 scan-code decoder.
// The master drives bytes and flushes; the slave (decoder) drives key state.
interface ps2_scancode_decoder_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       clear;
  logic [4:0] key_held;
  logic [4:0] key_press;
  logic       seq_error;

  modport master (
    output received_data,
    output received_data_en,
    output clear,
    input  key_held,
    input  key_press,
    input  seq_error
  );

  modport slave (
    input  received_data,
    input  received_data_en,
    input  clear,
    output key_held,
    output key_press,
    output seq_error
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set 2 scan-code decoder: tracks E0/F0 prefixes, keeps nine physical key
// flops, and merges arrows with WASD into held levels and press pulses.
module ps2_scancode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter bit          ALIAS_WASD     = 1'b1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  ps2_scancode_decoder_if.slave   bus
);

  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned PHYS_N = 9;
  localparam int unsigned KEY_N  = 5;
  localparam int unsigned IDX_W  = $clog2(PHYS_N);

  // Physical flop indices
  localparam int unsigned P_UP    = 0;
  localparam int unsigned P_LEFT  = 1;
  localparam int unsigned P_RIGHT = 2;
  localparam int unsigned P_DOWN  = 3;
  localparam int unsigned P_W     = 4;
  localparam int unsigned P_A     = 5;
  localparam int unsigned P_S     = 6;
  localparam int unsigned P_D     = 7;
  localparam int unsigned P_SPACE = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [PHYS_N-1:0]   r_phys;
  logic [PHYS_N-1:0]   w_phys_next;
  logic [KEY_N-1:0]    r_key_held;
  logic [KEY_N-1:0]    r_key_press;
  logic [KEY_N-1:0]    w_held_next;
  logic                r_seq_error;

  logic                w_byte;
  logic                w_is_e0;
  logic                w_is_f0;
  logic                w_timeout;
  logic                w_decode;
  logic                w_ext;
  logic                w_brk;
  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;

  // A strobe coincident with clear is dropped
  assign w_byte  = bus.received_data_en & ~bus.clear;
  assign w_is_e0 = (bus.received_data == 8'hE0);
  assign w_is_f0 = (bus.received_data == 8'hF0);

  // A byte arriving in the expiry cycle takes precedence over the watchdog
  assign w_timeout = (r_state != S_IDLE) & ~bus.received_data_en
                   & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (bus.clear || w_timeout) begin
      w_state_next = S_IDLE;
    end else if (w_byte) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_is_e0)      w_state_next = S_EXT;
          else if (w_is_f0) w_state_next = S_BRK;
          else              w_state_next = S_IDLE;
        end
        S_EXT: begin
          if (w_is_f0)      w_state_next = S_EXT_BRK;
          else if (w_is_e0) w_state_next = S_EXT;
          else              w_state_next = S_IDLE;
        end
        S_BRK:     w_state_next = S_IDLE;
        S_EXT_BRK: w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // Decode qualifiers for the byte that completes a sequence
  always_comb begin
    w_decode = 1'b0;
    w_ext    = 1'b0;
    w_brk    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_decode = w_byte & ~w_is_e0 & ~w_is_f0;
      end
      S_EXT: begin
        w_decode = w_byte & ~w_is_e0 & ~w_is_f0;
        w_ext    = 1'b1;
      end
      S_BRK: begin
        w_decode = w_byte;
        w_brk    = 1'b1;
      end
      S_EXT_BRK: begin
        w_decode = w_byte;
        w_ext    = 1'b1;
        w_brk    = 1'b1;
      end
      default: begin
        w_decode = 1'b0;
      end
    endcase
  end

  // Physical key lookup; extended-ness is part of the match
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    unique case ({w_ext, bus.received_data})
      9'h175: begin w_hit = 1'b1; w_idx = IDX_W'(P_UP);    end
      9'h16B: begin w_hit = 1'b1; w_idx = IDX_W'(P_LEFT);  end
      9'h174: begin w_hit = 1'b1; w_idx = IDX_W'(P_RIGHT); end
      9'h172: begin w_hit = 1'b1; w_idx = IDX_W'(P_DOWN);  end
      9'h01D: begin w_hit = 1'b1; w_idx = IDX_W'(P_W);     end
      9'h01C: begin w_hit = 1'b1; w_idx = IDX_W'(P_A);     end
      9'h01B: begin w_hit = 1'b1; w_idx = IDX_W'(P_S);     end
      9'h023: begin w_hit = 1'b1; w_idx = IDX_W'(P_D);     end
      9'h029: begin w_hit = 1'b1; w_idx = IDX_W'(P_SPACE); end
      default: begin
        w_hit = 1'b0;
        w_idx = '0;
      end
    endcase
  end

  // Make sets and break clears; repeats and stray breaks leave the flop as is
  always_comb begin
    w_phys_next = r_phys;
    if (bus.clear) begin
      w_phys_next = '0;
    end else if (w_decode && w_hit) begin
      w_phys_next[w_idx] = ~w_brk;
    end
  end

  // Logical keys: an arrow stays held while either it or its alias is down
  always_comb begin
    w_held_next    = '0;
    w_held_next[0] = w_phys_next[P_UP]    | (ALIAS_WASD & w_phys_next[P_W]);
    w_held_next[1] = w_phys_next[P_LEFT]  | (ALIAS_WASD & w_phys_next[P_A]);
    w_held_next[2] = w_phys_next[P_RIGHT] | (ALIAS_WASD & w_phys_next[P_D]);
    w_held_next[3] = w_phys_next[P_DOWN]  | (ALIAS_WASD & w_phys_next[P_S]);
    w_held_next[4] = w_phys_next[P_SPACE];
  end

  // Prefix watchdog counter; idle in IDLE and cleared by any strobe
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (bus.clear || bus.received_data_en || (r_state == S_IDLE) || w_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Key state and registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_phys      <= '0;
      r_key_held  <= '0;
      r_key_press <= '0;
      r_seq_error <= 1'b0;
    end else begin
      r_phys      <= w_phys_next;
      r_key_held  <= w_held_next;
      r_key_press <= w_held_next & ~r_key_held;
      r_seq_error <= w_timeout & ~bus.clear;
    end
  end

  assign bus.key_held  = r_key_held;
  assign bus.key_press = r_key_press;
  assign bus.seq_error = r_seq_error;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: one instance with WASD aliasing and
// one without, both fed the same byte stream.
module tb_ps2_scancode_decoder;

  localparam int unsigned TO = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   press_cnt_a [5];

  ps2_scancode_decoder_if bus_a ();
  ps2_scancode_decoder_if bus_b ();

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO), .ALIAS_WASD(1'b1)) dut_a (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus_a)
  );

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO), .ALIAS_WASD(1'b0)) dut_b (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Press pulses seen by the aliasing instance, sampled before each edge updates them
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (bus_a.key_press[i]) press_cnt_a[i] <= press_cnt_a[i] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic en, input logic clr);
    bus_a.received_data    = d;
    bus_a.received_data_en = en;
    bus_a.clear            = clr;
    bus_b.received_data    = d;
    bus_b.received_data_en = en;
    bus_b.clear            = clr;
  endtask

  // Called at a negedge; returns at the next negedge with outputs updated
  task automatic strobe(input logic [7:0] d);
    drive(d, 1'b1, 1'b0);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int snap;

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 5; i++) press_cnt_a[i] = 0;
    rst_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    idle(3);
    check_eq("reset_held", 32'(bus_a.key_held), 32'h0);
    check_eq("reset_press", 32'(bus_a.key_press), 32'h0);
    check_eq("reset_seq_error", 32'(bus_a.seq_error), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Arrow up make then break
    strobe(8'hE0);
    check_eq("up_prefix_no_change", 32'(bus_a.key_held), 32'h0);
    strobe(8'h75);
    check_eq("up_make_held", 32'(bus_a.key_held), 32'h01);
    check_eq("up_make_press", 32'(bus_a.key_press), 32'h01);
    idle(1);
    check_eq("up_press_one_cycle", 32'(bus_a.key_press), 32'h0);
    check_eq("up_still_held", 32'(bus_a.key_held), 32'h01);
    strobe(8'hE0);
    strobe(8'hF0);
    check_eq("up_break_prefix_hold", 32'(bus_a.key_held), 32'h01);
    strobe(8'h75);
    check_eq("up_break_held", 32'(bus_a.key_held), 32'h0);
    check_eq("up_break_no_press", 32'(bus_a.key_press), 32'h0);
    check_eq("up_noalias_inst", 32'(bus_b.key_held), 32'h0);

    // Alias overlap: A, then left arrow, release A, release left
    idle(1);
    snap = press_cnt_a[1];
    strobe(8'h1C);
    check_eq("alias_a_make_held", 32'(bus_a.key_held), 32'h02);
    check_eq("alias_a_make_press", 32'(bus_a.key_press), 32'h02);
    check_eq("noalias_a_ignored", 32'(bus_b.key_held), 32'h0);
    strobe(8'hE0);
    strobe(8'h6B);
    check_eq("alias_left_held", 32'(bus_a.key_held), 32'h02);
    check_eq("alias_left_no_press", 32'(bus_a.key_press), 32'h0);
    check_eq("noalias_left_press", 32'(bus_b.key_press), 32'h02);
    strobe(8'hF0);
    strobe(8'h1C);
    check_eq("alias_a_break_still_held", 32'(bus_a.key_held), 32'h02);
    check_eq("noalias_a_break_held", 32'(bus_b.key_held), 32'h02);
    strobe(8'hE0);
    strobe(8'hF0);
    strobe(8'h6B);
    check_eq("alias_left_break", 32'(bus_a.key_held), 32'h0);
    check_eq("noalias_left_break", 32'(bus_b.key_held), 32'h0);
    idle(1);
    check_eq("alias_single_pulse", 32'(press_cnt_a[1] - snap), 32'd1);

    // Typematic repeat of space, back to back
    snap = press_cnt_a[4];
    for (int i = 0; i < 5; i++) strobe(8'h29);
    check_eq("typematic_held", 32'(bus_a.key_held), 32'h10);
    idle(2);
    check_eq("typematic_one_pulse", 32'(press_cnt_a[4] - snap), 32'd1);

    // Flush with a simultaneous F0 strobe while up+space held
    strobe(8'hE0);
    strobe(8'h75);
    check_eq("flush_pre_held", 32'(bus_a.key_held), 32'h11);
    drive(8'hF0, 1'b1, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0);
    check_eq("flush_held", 32'(bus_a.key_held), 32'h0);
    check_eq("flush_press", 32'(bus_a.key_press), 32'h0);
    strobe(8'h29);
    check_eq("flush_state_idle", 32'(bus_a.key_held), 32'h10);
    strobe(8'hF0);
    strobe(8'h29);
    check_eq("space_release", 32'(bus_a.key_held), 32'h0);

    // Unlisted code consumed as a break; keypad 8 (non-extended 75) ignored
    strobe(8'hF0);
    strobe(8'hAA);
    strobe(8'h75);
    check_eq("unlisted_and_keypad", 32'(bus_a.key_held), 32'h0);

    // Watchdog expiry on a lone E0
    strobe(8'hE0);
    idle(TO - 1);
    check_eq("wd_before_expiry", 32'(bus_a.seq_error), 32'h0);
    idle(1);
    check_eq("wd_seq_error", 32'(bus_a.seq_error), 32'h1);
    idle(1);
    check_eq("wd_seq_error_one_cycle", 32'(bus_a.seq_error), 32'h0);
    strobe(8'h75);
    check_eq("wd_byte_non_extended", 32'(bus_a.key_held), 32'h0);

    // Strobe in the expiry cycle wins
    strobe(8'hE0);
    idle(TO - 1);
    strobe(8'h75);
    check_eq("wd_late_byte_extended", 32'(bus_a.key_held), 32'h01);
    check_eq("wd_late_no_error", 32'(bus_a.seq_error), 32'h0);
    idle(1);
    check_eq("wd_late_no_error_next", 32'(bus_a.seq_error), 32'h0);
    strobe(8'hE0);
    strobe(8'hF0);
    strobe(8'h75);
    check_eq("wd_late_release", 32'(bus_a.key_held), 32'h0);

    // Reset mid-sequence
    strobe(8'h29);
    strobe(8'hE0);
    strobe(8'hF0);
    check_eq("rst_pre_held", 32'(bus_a.key_held), 32'h10);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_held", 32'(bus_a.key_held), 32'h0);
    check_eq("rst_async_press", 32'(bus_a.key_press), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    strobe(8'h75);
    check_eq("rst_partial_lost", 32'(bus_a.key_held), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
